// File: rtl/timer.sv
// timer -- DMG timer peripheral on the CPU system bus.
//
// Holds DIV/TIMA/TMA/TAC at BASE_ADDR..BASE_ADDR+3 and raises a one-clk
// interrupt request when TIMA overflows. One clk is one T-cycle (4 MHz).
//
// Ports:
//   clk          system clock
//   reset        synchronous reset, active high
//   bus_addr     CPU bus address
//   bus_enable   access strobe, one clk per M-cycle
//   bus_write    1 = write, 0 = read (qualified by bus_enable)
//   bus_wdata    CPU write data
//   bus_rdata    registered read data, holds until the next selected read
//   bus_selected combinational address decode for BASE_ADDR..BASE_ADDR+3
//   irq_timer    one-clk timer interrupt request pulse
//
// Configuration macro: TIMER_OVERFLOW_DELAY_EN
//   defined   : TIMA reads 00 for 4 clks after overflow, then reloads from TMA
//               and pulses irq_timer (hardware-accurate reload window).
//   undefined : overflow loads TMA and pulses irq_timer in the same clk.

module timer #(
  parameter logic [15:0] BASE_ADDR = 16'hFF04,
  parameter logic [15:0] RESET_DIV = 16'hABCC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bus_addr,
  input  logic        bus_enable,
  input  logic        bus_write,
  input  logic [7:0]  bus_wdata,
  output logic [7:0]  bus_rdata,
  output logic        bus_selected,
  output logic        irq_timer
);

`ifdef TIMER_OVERFLOW_DELAY_EN
  typedef enum logic [1:0] {
    OVF_IDLE,
    OVF_PENDING,
    OVF_RELOAD
  } ovf_state_t;

  ovf_state_t ovf_state;
  logic [1:0] pend_cnt;
`endif

  logic [15:0] div_ctr;
  logic [7:0]  tima;
  logic [7:0]  tma;
  logic [2:0]  tac;

  logic [15:0] offset;
  logic        rd_en;
  logic        wr_div;
  logic        wr_tima;
  logic        wr_tma;
  logic        wr_tac;
  logic [15:0] div_next;
  logic [7:0]  tma_next;
  logic [2:0]  tac_next;
  logic        sig_pre_bit;
  logic        sig_post_bit;
  logic        sig_pre;
  logic        sig_post;
  logic        tick;
  logic [7:0]  rd_value;

  // Decode as an offset from the base so a window near FFFF still works.
  always_comb begin
    offset       = bus_addr - BASE_ADDR;
    bus_selected = (offset[15:2] == 14'd0);
    rd_en        = bus_enable & bus_selected & ~bus_write;
    wr_div       = bus_enable & bus_selected & bus_write & (offset[1:0] == 2'd0);
    wr_tima      = bus_enable & bus_selected & bus_write & (offset[1:0] == 2'd1);
    wr_tma       = bus_enable & bus_selected & bus_write & (offset[1:0] == 2'd2);
    wr_tac       = bus_enable & bus_selected & bus_write & (offset[1:0] == 2'd3);
  end

  always_comb begin
    div_next = wr_div ? '0 : div_ctr + 16'd1;
    tma_next = wr_tma ? bus_wdata : tma;
    tac_next = wr_tac ? bus_wdata[2:0] : tac;
  end

  // The tick is a falling edge of the selected divider tap, evaluated across
  // the edge with both the old and the new DIV/TAC. This is what lets DIV
  // writes and TAC changes produce a spurious increment.
  always_comb begin
    sig_pre_bit = 1'b0;
    case (tac[1:0])
      2'b00:   sig_pre_bit = div_ctr[9];
      2'b01:   sig_pre_bit = div_ctr[3];
      2'b10:   sig_pre_bit = div_ctr[5];
      default: sig_pre_bit = div_ctr[7];
    endcase
    sig_post_bit = 1'b0;
    case (tac_next[1:0])
      2'b00:   sig_post_bit = div_next[9];
      2'b01:   sig_post_bit = div_next[3];
      2'b10:   sig_post_bit = div_next[5];
      default: sig_post_bit = div_next[7];
    endcase
    sig_pre  = tac[2] & sig_pre_bit;
    sig_post = tac_next[2] & sig_post_bit;
    tick     = sig_pre & ~sig_post;
  end

  always_comb begin
    rd_value = '1;
    case (offset[1:0])
      2'd0:    rd_value = div_ctr[15:8];
      2'd1:    rd_value = tima;
      2'd2:    rd_value = tma;
      default: rd_value = {5'b11111, tac};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_ctr   <= RESET_DIV;
      tima      <= '0;
      tma       <= '0;
      tac       <= '0;
      bus_rdata <= '1;
      irq_timer <= 1'b0;
`ifdef TIMER_OVERFLOW_DELAY_EN
      ovf_state <= OVF_IDLE;
      pend_cnt  <= '0;
`endif
    end else begin
      div_ctr   <= div_next;
      tma       <= tma_next;
      tac       <= tac_next;
      irq_timer <= 1'b0;
      if (rd_en) begin
        bus_rdata <= rd_value;
      end
`ifdef TIMER_OVERFLOW_DELAY_EN
      case (ovf_state)
        // Reload clk: TIMA follows TMA (including a TMA written now);
        // TIMA writes and ticks are discarded.
        OVF_RELOAD: begin
          tima      <= tma_next;
          ovf_state <= OVF_IDLE;
        end
        // TIMA sits at 00; a CPU write here cancels reload and interrupt.
        OVF_PENDING: begin
          if (wr_tima) begin
            tima      <= bus_wdata;
            ovf_state <= OVF_IDLE;
          end else if (pend_cnt == 2'd3) begin
            tima      <= tma_next;
            irq_timer <= 1'b1;
            ovf_state <= OVF_RELOAD;
          end else begin
            pend_cnt <= pend_cnt + 2'd1;
          end
        end
        default: begin
          if (wr_tima) begin
            tima <= bus_wdata;
          end else if (tick) begin
            if (tima == 8'hFF) begin
              tima      <= '0;
              pend_cnt  <= '0;
              ovf_state <= OVF_PENDING;
            end else begin
              tima <= tima + 8'd1;
            end
          end
        end
      endcase
`else
      if (wr_tima) begin
        tima <= bus_wdata;
      end else if (tick) begin
        if (tima == 8'hFF) begin
          tima      <= tma_next;
          irq_timer <= 1'b1;
        end else begin
          tima <= tima + 8'd1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_timer.sv
// tb_timer -- self-checking bench for the DMG timer peripheral.
//
// A transaction-level model of the timer registers runs alongside the DUT and
// is compared against bus_rdata, irq_timer and bus_selected every cycle.
// Directed scenarios add literal expectations for key values.
// Honours TIMER_OVERFLOW_DELAY_EN the same way the design does.

module tb_timer;

`ifdef TIMER_OVERFLOW_DELAY_EN
  localparam int DELAY = 4;
`else
  localparam int DELAY = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bus_addr;
  logic        bus_enable;
  logic        bus_write;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_selected;
  logic        irq_timer;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state
  logic [15:0] m_div;
  logic [7:0]  m_tima;
  logic [7:0]  m_tma;
  logic [2:0]  m_tac;
  logic [7:0]  m_rdata;
  bit          m_irq;
  int          m_hold;    // clks left with TIMA parked at 00 after overflow
  bit          m_reload;  // in the clk where TIMA tracks TMA
  bit          m_ovf;     // sticky overflow marker, cleared by scenarios

  int tap_bit [4] = '{9, 3, 5, 7};

  int zeros;
  int irqs;
  int after;
  int n;

  timer #(
    .BASE_ADDR(16'hFF04),
    .RESET_DIV(16'hABCC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus_addr    (bus_addr),
    .bus_enable  (bus_enable),
    .bus_write   (bus_write),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata),
    .bus_selected(bus_selected),
    .irq_timer   (irq_timer)
  );

  always #5 clk = ~clk;

  function automatic bit in_range(input logic [15:0] a);
    return (a >= 16'hFF04) && (a <= 16'hFF07);
  endfunction

  function automatic bit tap(input logic [15:0] d, input logic [2:0] c);
    logic [1:0] s;
    s = c[1:0];
    return c[2] && d[tap_bit[s]];
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out at %0t", name, $time);
  endtask

  // Advance the model by one clk edge using the inputs the DUT sampled.
  task automatic model_step();
    logic [15:0] diff;
    logic [15:0] nd;
    logic [2:0]  nt;
    logic [7:0]  nm;
    logic [1:0]  r;
    bit sel, rd, wr, tk;
    if (reset) begin
      m_div    = 16'hABCC;
      m_tima   = 8'h00;
      m_tma    = 8'h00;
      m_tac    = 3'd0;
      m_rdata  = 8'hFF;
      m_irq    = 1'b0;
      m_hold   = 0;
      m_reload = 1'b0;
      return;
    end
    sel  = in_range(bus_addr);
    diff = bus_addr - 16'hFF04;
    r    = diff[1:0];
    rd   = bus_enable && sel && !bus_write;
    wr   = bus_enable && sel && bus_write;
    if (rd) begin
      case (r)
        2'd0:    m_rdata = m_div[15:8];
        2'd1:    m_rdata = m_tima;
        2'd2:    m_rdata = m_tma;
        default: m_rdata = {5'b11111, m_tac};
      endcase
    end
    nd = (wr && r == 2'd0) ? 16'h0000 : m_div + 16'd1;
    nt = (wr && r == 2'd3) ? bus_wdata[2:0] : m_tac;
    nm = (wr && r == 2'd2) ? bus_wdata : m_tma;
    tk = tap(m_div, m_tac) && !tap(nd, nt);
    m_irq = 1'b0;
    if (m_reload) begin
      m_tima   = nm;
      m_reload = 1'b0;
    end else if (m_hold > 0) begin
      if (wr && r == 2'd1) begin
        m_tima = bus_wdata;
        m_hold = 0;
      end else begin
        m_hold--;
        if (m_hold == 0) begin
          m_tima   = nm;
          m_irq    = 1'b1;
          m_reload = 1'b1;
        end
      end
    end else if (wr && r == 2'd1) begin
      m_tima = bus_wdata;
    end else if (tk) begin
      if (m_tima == 8'hFF) begin
        m_ovf = 1'b1;
        if (DELAY > 0) begin
          m_tima = 8'h00;
          m_hold = DELAY;
        end else begin
          m_tima = nm;
          m_irq  = 1'b1;
        end
      end else begin
        m_tima = m_tima + 8'd1;
      end
    end
    m_div = nd;
    m_tac = nt;
    m_tma = nm;
  endtask

  task automatic step(input bit en, input bit wr, input logic [15:0] a, input logic [7:0] d);
    bus_enable = en;
    bus_write  = wr;
    bus_addr   = a;
    bus_wdata  = d;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic wr_reg(input logic [15:0] a, input logic [7:0] d);
    step(1'b1, 1'b1, a, d);
  endtask

  task automatic rd_reg(input logic [15:0] a);
    step(1'b1, 1'b0, a, 8'h00);
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("cyc_rdata", {8'h00, bus_rdata}, {8'h00, m_rdata});
        check("cyc_irq", {15'h0, irq_timer}, {15'h0, m_irq});
        check("cyc_sel", {15'h0, bus_selected}, {15'h0, in_range(bus_addr)});
      end
    end
  end

  initial begin
    reset      = 1'b1;
    bus_enable = 1'b0;
    bus_write  = 1'b0;
    bus_addr   = 16'h0000;
    bus_wdata  = 8'h00;
    m_ovf      = 1'b0;
    idle();
    chk_en = 1'b1;
    check("reset_rdata", {8'h00, bus_rdata}, 16'h00FF);
    check("reset_irq", {15'h0, irq_timer}, 16'h0000);
    idle();
    reset = 1'b0;

    // DIV after reset and DIV clear
    rd_reg(16'hFF04);
    check("div_after_reset", {8'h00, bus_rdata}, 16'h00AB);
    wr_reg(16'hFF04, 8'h5A);
    rd_reg(16'hFF04);
    check("div_cleared", {8'h00, bus_rdata}, 16'h0000);

    // TAC readback and unselected access
    wr_reg(16'hFF07, 8'hFB);
    wr_reg(16'hFF07, 8'h00);
    rd_reg(16'hFF07);
    check("tac_read", {8'h00, bus_rdata}, 16'h00F8);
    rd_reg(16'hFF08);
    check("ff08_sel", {15'h0, bus_selected}, 16'h0000);
    check("ff08_hold", {8'h00, bus_rdata}, 16'h00F8);
    rd_reg(16'hFF03);
    check("ff03_sel", {15'h0, bus_selected}, 16'h0000);

    // Overflow and reload window
    wr_reg(16'hFF07, 8'h05);
    wr_reg(16'hFF06, 8'h20);
    wr_reg(16'hFF05, 8'hFE);
    zeros = 0;
    irqs  = 0;
    after = 0;
    for (int i = 0; i < 200; i++) begin
      rd_reg(16'hFF05);
      if (bus_rdata == 8'h00) zeros++;
      if (irq_timer) irqs++;
      if (irqs > 0) begin
        after++;
        if (after == 3) break;
      end
    end
    check("ovf_irq_pulses", irqs[15:0], 16'd1);
    check("ovf_zero_reads", zeros[15:0], DELAY[15:0]);
    rd_reg(16'hFF05);
    check("ovf_reload_val", {8'h00, bus_rdata}, 16'h0020);

    // TIMA write right after overflow cancels the pending interrupt
    wr_reg(16'hFF05, 8'hFF);
    m_ovf = 1'b0;
    n = 0;
    while (!m_ovf && n < 100) begin idle(); n++; end
    if (!m_ovf) timeout_fail("cancel_wait");
    wr_reg(16'hFF05, 8'h77);
    irqs = int'(irq_timer);
    rd_reg(16'hFF05);
    check("cancel_tima", {8'h00, bus_rdata}, 16'h0077);
    irqs += int'(irq_timer);
    for (int i = 0; i < 6; i++) begin
      idle();
      irqs += int'(irq_timer);
    end
    check("cancel_irq", irqs[15:0], 16'd0);

    // TIMA write on the interrupt clk
    wr_reg(16'hFF05, 8'hFF);
    n = 0;
    while (!m_irq && n < 100) begin idle(); n++; end
    if (!m_irq) timeout_fail("tima_on_reload_wait");
    wr_reg(16'hFF05, 8'h33);
    rd_reg(16'hFF05);
    check("tima_on_reload", {8'h00, bus_rdata}, (DELAY > 0) ? 16'h0020 : 16'h0033);

    // TMA write on the interrupt clk
    wr_reg(16'hFF05, 8'hFF);
    n = 0;
    while (!m_irq && n < 100) begin idle(); n++; end
    if (!m_irq) timeout_fail("tma_on_reload_wait");
    wr_reg(16'hFF06, 8'h44);
    rd_reg(16'hFF05);
    check("tma_on_reload", {8'h00, bus_rdata}, (DELAY > 0) ? 16'h0044 : 16'h0020);
    wr_reg(16'hFF06, 8'h20);

    // DIV write while the selected tap is high produces one increment
    n = 0;
    while (m_div[3:0] != 4'h8 && n < 40) begin idle(); n++; end
    if (m_div[3:0] != 4'h8) timeout_fail("div_tap_wait");
    wr_reg(16'hFF05, 8'h10);
    wr_reg(16'hFF04, 8'h00);
    rd_reg(16'hFF05);
    check("div_write_tick", {8'h00, bus_rdata}, 16'h0011);

    // All tap selections, with mid-stream TAC switches
    for (int t = 4; t < 8; t++) begin
      wr_reg(16'hFF07, 8'(t));
      for (int i = 0; i < 600; i++) begin
        if (i % 4 == 0) rd_reg(16'hFF05);
        else if (i % 37 == 0) rd_reg(16'hFF04);
        else idle();
      end
    end
    wr_reg(16'hFF07, 8'h05);

    // Reset in the middle of an overflow
    wr_reg(16'hFF05, 8'hFF);
    m_ovf = 1'b0;
    n = 0;
    while (!m_ovf && n < 100) begin idle(); n++; end
    if (!m_ovf) timeout_fail("reset_wait");
    reset = 1'b1;
    idle();
    reset = 1'b0;
    check("midreset_rdata", {8'h00, bus_rdata}, 16'h00FF);
    irqs = 0;
    for (int i = 0; i < 10; i++) begin
      idle();
      irqs += int'(irq_timer);
    end
    check("midreset_irq", irqs[15:0], 16'd0);
    rd_reg(16'hFF05);
    check("midreset_tima", {8'h00, bus_rdata}, 16'h0000);
    rd_reg(16'hFF07);
    check("midreset_tac", {8'h00, bus_rdata}, 16'h00F8);
    idle();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
